psum_collector: RTL and testbench
=================================

PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 SHALL have parameter Data_width, default 8, bit width of one partial sum.
REQ-002 SHALL have parameter Cols, default 4, number of array columns drained.
REQ-003 SHALL have parameter Rows, default 4, array depth; sets fill latency.
REQ-004 SHALL have parameter Fifo_depth, default 4, output buffer entries (power of 2).
REQ-005 SHALL provide port iClk  input  1  sole clock, rising edge.
REQ-006 SHALL provide port iRest_n  input  1  asynchronous active-low reset.
REQ-007 SHALL provide port Start  input  1  pulse; begins one drain job when sampled high in IDLE.
REQ-008 SHALL provide port Num_rows  input  8  output rows to collect, sampled with Start.
REQ-009 SHALL provide port Psum_f_top  input  Cols*Data_width  bottom-PE-row psums; column c at bits [c*Data_width +: Data_width].
REQ-010 SHALL provide port Row_out  output  Cols*Data_width  deskewed row, same packing.
REQ-011 SHALL provide port Row_valid  output  1  Row_out holds a valid row.
REQ-012 SHALL provide port Row_ready  input  1  consumer accepts Row_out when Row_valid and Row_ready are both high.
REQ-013 SHALL provide ports Busy, Done, Overflow  output  1 each  job active; one-cycle completion pulse; sticky loss flag.

Function
REQ-014 Timing: cycle 0 = edge sampling Start; column c of row r SHALL be valid on Psum_f_top at cycle Rows + r + c, r = 0..Num_rows-1.
REQ-015 Column c SHALL pass through a (Cols-1-c)-stage register delay line, aligning all columns of row r at cycle Rows + r + Cols - 1.
REQ-016 FSM states: IDLE, FILL, DRAIN, FLUSH, DONE; encoding from the shared package.
REQ-017 IDLE -> FILL on Start; Busy SHALL be high in FILL, DRAIN, FLUSH.
REQ-018 FILL SHALL count Rows + Cols - 1 cycles, then enter DRAIN.
REQ-019 DRAIN SHALL push one aligned row per cycle into the FIFO for Num_rows cycles, then enter FLUSH.
REQ-020 FLUSH -> DONE when the FIFO is empty; DONE SHALL assert Done for exactly one cycle, then return to IDLE.
REQ-021 Num_rows = 0: IDLE -> DONE directly; no row SHALL be produced.
REQ-022 Start outside IDLE SHALL be ignored; Num_rows SHALL be latched only at accepted Start.
REQ-023 FIFO: Row_valid = not empty; Row_out = head entry (first-word fall-through); pop on Row_valid & Row_ready.
REQ-024 A push to a full FIFO without a simultaneous pop SHALL drop the row and set Overflow; Overflow SHALL clear only on reset or accepted Start.
REQ-025 A simultaneous push and pop on a full FIFO SHALL succeed with no loss.
REQ-026 Psum data SHALL pass bit-exact; no arithmetic or truncation.
REQ-027 Psum_f_top SHALL be ignored (delay lines still shift) outside DRAIN capture.

Reset
REQ-028 iRest_n low SHALL immediately force IDLE, clear counters, delay lines and FIFO pointers, and drive Row_out=0, Row_valid=0, Busy=0, Done=0, Overflow=0.
REQ-029 Reset mid-job SHALL discard all buffered rows; the first job after release SHALL behave as if from power-up.
REQ-030 Deassertion SHALL need no synchronisation inside the block; Start in the release cycle SHALL be honoured.

Structure
REQ-031 Shared package SHALL hold FSM state constants and default values of Data_width, Cols, Rows, Fifo_depth.
REQ-032 FIFO SHALL be a separate sub-module psum_fifo (width Cols*Data_width, depth Fifo_depth, full/empty outputs).
REQ-033 Delay lines SHALL be generate-loop registers in psum_collector.

Verification (Cols=4, Rows=4, Data_width=8)
REQ-034 Start, Num_rows=3, column c of row r driven with 16*r+c at cycle 4+r+c, Row_ready=1 -> rows {0x03,0x02,0x01,0x00}-packed, then 0x13..0x10, then 0x23..0x20; first Row_valid at cycle 8; Done once; Overflow=0.
REQ-035 Num_rows=6, Row_ready=0 throughout DRAIN -> 4 rows held, rows 4-5 dropped, Overflow=1; raising Row_ready yields rows 0-3 in order, then Done.
REQ-036 Num_rows=0 -> Done one cycle after Start; Row_valid never asserts; Busy stays 0.
REQ-037 Second Start pulse during DRAIN -> ignored; row count and Done timing unchanged.
REQ-038 iRest_n low for one cycle during DRAIN -> all outputs 0 asynchronously; new job after release produces correct rows.

Source files
------------

// File: rtl/psum_collector_pkg.sv
// rtl/psum_collector_pkg.sv - shared FSM encoding and default sizes for the psum collector
package psum_collector_pkg;

  localparam int PSUM_DATA_WIDTH = 8;
  localparam int PSUM_COLS       = 4;
  localparam int PSUM_ROWS       = 4;
  localparam int PSUM_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/psum_collector_fifo.sv
// rtl/psum_collector_fifo.sv - first-word fall-through row buffer; depth must be a power of 2 (>= 2)
module psum_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - deskews systolic-array column outputs into whole rows and buffers them
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int Data_width = PSUM_DATA_WIDTH,
  parameter int Cols       = PSUM_COLS,
  parameter int Rows       = PSUM_ROWS,
  parameter int Fifo_depth = PSUM_FIFO_DEPTH
) (
  input  logic                       iClk,
  input  logic                       iRest_n,
  input  logic                       Start,
  input  logic [7:0]                 Num_rows,
  input  logic [Cols*Data_width-1:0] Psum_f_top,
  output logic [Cols*Data_width-1:0] Row_out,
  output logic                       Row_valid,
  input  logic                       Row_ready,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Overflow
);

  localparam int RowW = Cols * Data_width;
  // The Start cycle counts as the first fill cycle, so DRAIN is entered one edge
  // before the first aligned row is captured.
  localparam logic [15:0] FILL_LAST = 16'(Rows + Cols - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  rows_q;
  logic        busy_q, done_q, ovf_q;

  logic [RowW-1:0] aligned;
  logic            push, pop, fifo_full, fifo_empty, fifo_drop;

  for (genvar c = 0; c < Cols; c++) begin : g_col
    localparam int Stages = Cols - 1 - c;
    if (Stages == 0) begin : g_pass
      assign aligned[c*Data_width +: Data_width] = Psum_f_top[c*Data_width +: Data_width];
    end else begin : g_dly
      logic [Data_width-1:0] dly_q [Stages];
      always_ff @(posedge iClk or negedge iRest_n) begin
        if (!iRest_n) begin
          for (int i = 0; i < Stages; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= Psum_f_top[c*Data_width +: Data_width];
          for (int i = 1; i < Stages; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign aligned[c*Data_width +: Data_width] = dly_q[Stages-1];
    end
  end

  assign push = (state_q == ST_DRAIN);
  assign pop  = Row_valid & Row_ready;

  psum_fifo #(
    .Width (RowW),
    .Depth (Fifo_depth)
  ) u_fifo (
    .clk_i   (iClk),
    .rst_ni  (iRest_n),
    .push_i  (push),
    .data_i  (aligned),
    .pop_i   (pop),
    .data_o  (Row_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  assign Row_valid = ~fifo_empty;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Overflow  = ovf_q;

  always_ff @(posedge iClk or negedge iRest_n) begin
    if (!iRest_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rows_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fifo_drop) ovf_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            ovf_q  <= 1'b0;
            rows_q <= Num_rows;
            cnt_q  <= 16'd1;
            if (Num_rows == 8'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FILL;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (cnt_q >= FILL_LAST - 16'd1) begin
            state_q <= ST_DRAIN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == {8'h00, rows_q} - 16'd1) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_psum_collector.sv
// tb/tb_psum_collector.sv - scoreboard bench for psum_collector with directed drain jobs
module tb_psum_collector;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int NR = 4;
  localparam int FD = 4;
  localparam int RW = NC * DW;

  logic          iClk = 1'b0;
  logic          iRest_n = 1'b0;
  logic          Start = 1'b0;
  logic [7:0]    Num_rows = 8'd0;
  logic [RW-1:0] Psum_f_top = '0;
  logic [RW-1:0] Row_out;
  logic          Row_valid;
  logic          Row_ready = 1'b1;
  logic          Busy, Done, Overflow;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q [$];

  psum_collector #(
    .Data_width (DW),
    .Cols       (NC),
    .Rows       (NR),
    .Fifo_depth (FD)
  ) dut (
    .iClk       (iClk),
    .iRest_n    (iRest_n),
    .Start      (Start),
    .Num_rows   (Num_rows),
    .Psum_f_top (Psum_f_top),
    .Row_out    (Row_out),
    .Row_valid  (Row_valid),
    .Row_ready  (Row_ready),
    .Busy       (Busy),
    .Done       (Done),
    .Overflow   (Overflow)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] row_val(input int r);
    logic [RW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*DW +: DW] = 8'(16*r + c);
    return v;
  endfunction

  // Column c of row r is presented for the edge Rows + r + c; anything else is junk.
  function automatic logic [RW-1:0] psum_for(input int k, input int n);
    logic [RW-1:0] v;
    for (int c = 0; c < NC; c++) begin
      int r;
      r = k - NR - c;
      v[c*DW +: DW] = (r >= 0 && r < n) ? 8'(16*r + c) : 8'hEE;
    end
    return v;
  endfunction

  always @(negedge iClk) begin
    if (iRest_n && Row_valid && Row_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_row: got %0h expected no row", Row_out);
      end else begin
        chk("row_data", Row_out, exp_q.pop_front());
      end
    end
  end

  task automatic run_job(input int n, input int n_exp, input int kmax, input int restart_k,
                         output int first_v, output int done_cyc, output int done_cnt,
                         output bit busy_seen, output logic ovf0);
    first_v = -1; done_cyc = -1; done_cnt = 0; busy_seen = 1'b0; ovf0 = 1'bx;
    for (int r = 0; r < n_exp; r++) exp_q.push_back(row_val(r));
    Start = 1'b1;
    Num_rows = 8'(n);
    Psum_f_top = '0;
    for (int k = 0; k <= kmax; k++) begin
      if (k > 0) begin
        Psum_f_top = psum_for(k, n);
        Start = (k == restart_k);
        Num_rows = (k == restart_k) ? 8'd5 : 8'(n);
      end
      @(posedge iClk);
      #1;
      if (k == 0) ovf0 = Overflow;
      if (Row_valid && first_v < 0) first_v = k + 1;
      if (Done) begin
        done_cnt++;
        done_cyc = k + 1;
      end
      if (Busy) busy_seen = 1'b1;
    end
    Start = 1'b0;
  endtask

  task automatic count_done(input int bound, output int cnt);
    cnt = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge iClk);
      #1;
      if (Done) cnt++;
    end
  endtask

  initial begin
    int fv, dc, dn, cnt;
    bit bs;
    logic o0;

    #2;
    chk("reset_row_valid", Row_valid, 0);
    chk("reset_row_out", Row_out, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_overflow", Overflow, 0);
    @(posedge iClk);
    @(posedge iClk);
    #1;
    iRest_n = 1'b1;

    // Three rows, consumer always ready, Start in the reset release cycle.
    Row_ready = 1'b1;
    run_job(3, 3, 16, -1, fv, dc, dn, bs, o0);
    chk("t1_first_valid_cycle", 64'(fv), 64'd8);
    chk("t1_done_cycle", 64'(dc), 64'd12);
    chk("t1_done_count", 64'(dn), 64'd1);
    chk("t1_busy_seen", 64'(bs), 64'd1);
    chk("t1_overflow", Overflow, 0);
    chk("t1_rows_left", 64'(exp_q.size()), 64'd0);

    // Empty job.
    run_job(0, 0, 5, -1, fv, dc, dn, bs, o0);
    chk("t2_done_cycle", 64'(dc), 64'd1);
    chk("t2_done_count", 64'(dn), 64'd1);
    chk("t2_busy_seen", 64'(bs), 64'd0);
    chk("t2_no_valid", 64'(fv), 64'hFFFF_FFFF_FFFF_FFFF);

    // Six rows with a stalled consumer: four kept, two dropped.
    Row_ready = 1'b0;
    run_job(6, 4, 14, -1, fv, dc, dn, bs, o0);
    chk("t3_first_valid_cycle", 64'(fv), 64'd8);
    chk("t3_overflow", Overflow, 1);
    chk("t3_no_done_while_full", 64'(dn), 64'd0);
    chk("t3_busy", Busy, 1);
    Row_ready = 1'b1;
    count_done(20, cnt);
    chk("t3_done_count", 64'(cnt), 64'd1);
    chk("t3_rows_left", 64'(exp_q.size()), 64'd0);
    chk("t3_overflow_sticky", Overflow, 1);

    // Second Start during DRAIN is ignored; Overflow clears on accepted Start.
    run_job(3, 3, 16, 8, fv, dc, dn, bs, o0);
    chk("t4_overflow_cleared", 64'(o0), 64'd0);
    chk("t4_done_cycle", 64'(dc), 64'd12);
    chk("t4_done_count", 64'(dn), 64'd1);
    chk("t4_rows_left", 64'(exp_q.size()), 64'd0);

    // Reset mid-DRAIN, then a fresh two-row job.
    run_job(3, 3, 8, -1, fv, dc, dn, bs, o0);
    @(negedge iClk);
    iRest_n = 1'b0;
    #1;
    chk("t5_rst_row_valid", Row_valid, 0);
    chk("t5_rst_row_out", Row_out, 0);
    chk("t5_rst_busy", Busy, 0);
    chk("t5_rst_done", Done, 0);
    chk("t5_rst_overflow", Overflow, 0);
    exp_q.delete();
    @(posedge iClk);
    #1;
    iRest_n = 1'b1;
    run_job(2, 2, 14, -1, fv, dc, dn, bs, o0);
    chk("t5_first_valid_cycle", 64'(fv), 64'd8);
    chk("t5_done_cycle", 64'(dc), 64'd11);
    chk("t5_done_count", 64'(dn), 64'd1);
    chk("t5_rows_left", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
